wts_channel_slot_scheduler: RTL
===============================

Name: wts_channel_slot_scheduler

Overview:
- Sequences the time-multiplexed 5-channel ADSR envelope datapath. Generates the `active` channel-slot index (0..4 = channel update strobe, 5 = no-operation).
- Captures asynchronous per-channel key requests from the register interface and holds them pending. Each request is issued as a one-cycle ch_key_* pulse aligned exactly with that channel's `active` strobe.
- Sits between the CPU register block and the envelope generator / wave datapath.

Parameters:
- SLOT_CYCLES, 4, clk cycles per slot; legal range 1..16.
- NOP_SLOTS, 1, idle slots appended after slot 4 each frame; legal range 0..3.

Ports:
- clk  in  1  system clock
- nreset  in  1  async reset, active-low
- enable  in  1  1 = sequencer runs; 0 = freeze
- key_on_req  in  5  per-channel key-on request pulse (bit n = channel n)
- key_release_req  in  5  per-channel key-release request pulse
- key_off_req  in  5  per-channel key-off request pulse
- active  out  3  0..4 = update channel n this cycle; 5 = no operation
- slot  out  3  current slot index, 0..4+NOP_SLOTS
- frame_start  out  1  one-cycle pulse coincident with active=0
- ch_key_on  out  1  key-on for the channel named by active
- ch_key_release  out  1  key-release for the channel named by active
- ch_key_off  out  1  key-off for the channel named by active
- pending  out  5  bit n = channel n has an unissued event

Behaviour:
- Reset (async, nreset=0):
  - active=5, slot=0, frame_start=0, ch_key_*=0, pending=0.
  - Internal cycle counter cyc=0, slot counter=0, per-channel event registers=NONE.
- Counters, advancing on every clk edge while enable=1:
  - cyc counts 0..SLOT_CYCLES-1. On wrap, slot increments 0..4+NOP_SLOTS, then wraps to 0.
  - Frame length = (5+NOP_SLOTS)*SLOT_CYCLES cycles.
- All outputs are registered and computed from pre-edge counter state.
  - active <= slot if (cyc==0 && slot<=4 && enable), else 5.
  - slot output mirrors the slot counter.
- Consequence: active=ch is asserted for exactly one cycle per slot. All other cycles, and all NOP slots, show 5. This guarantees exactly one envelope update per channel per frame.
- Latency from reset release: active=0 visible after the 1st clk edge; active=k after edge 1+k*SLOT_CYCLES; repeats every frame length.
- SLOT_CYCLES=1: strobes are back-to-back (0,1,2,3,4, then NOP_SLOTS cycles of 5).
- Per-channel event register, 2 bits: NONE / ON / RELEASE / OFF.
  - Any request pulse on channel n overwrites its event register; a later request replaces an unissued earlier one.
  - Same-cycle requests on one channel: OFF > RELEASE > ON.
- Issue:
  - On the edge that loads active<=n, the ch_key_* registers load the decode of event[n].
  - Exactly one ch_key_* goes high, or none if event[n] is NONE. event[n] clears to NONE on that same edge.
  - ch_key_* is 0 whenever active=5.
- Simultaneous request and issue for the same channel on the same edge:
  - The old event is issued.
  - The new request is stored and stays pending until the next frame; it is not lost and not merged.
- enable=0:
  - Counters hold; active=5; ch_key_*=0; frame_start=0.
  - Requests still accumulate in the event registers.
  - On re-enable, sequencing resumes from the held counter position, not from slot 0.
- Reset mid-frame discards all pending events immediately. No ch_key_* pulse appears during or after reset until a new request arrives.
- pending[n] = (event[n] != NONE), registered with the event registers.
- Requests on bits for channels not present: none exist, since all 5 bits are valid.

Test Plan:
- Reset release, defaults (SLOT_CYCLES=4, NOP_SLOTS=1) -> active=0 after edge 1, 1 after edge 5, 4 after edge 17; 5 on all other cycles; active=0 again after edge 25; frame_start high only with active=0.
- key_on_req[2] pulsed at cycle 3 -> pending[2]=1; ch_key_on=1 only in the cycle active=2 (after edge 9); pending[2] clears on that edge; no pulse in later frames.
- key_on_req[1] then key_off_req[1] before slot 1 -> only ch_key_off=1 at active=1. Same-cycle key_release_req[3]+key_on_req[3] -> ch_key_release=1 at active=3.
- key_on_req[0] sampled on the same edge that loads active=0 with event[0]=RELEASE -> ch_key_release this frame; ch_key_on at active=0 of the next frame.
- enable=0 during slot 2 for 10 cycles with key_off_req[4] pulsed -> active=5 and ch_key_*=0 throughout; after re-enable, slot 2 resumes; ch_key_off at active=4.
- nreset asserted with pending=5'b10101 -> outputs return to reset values asynchronously; after release, no ch_key_* pulses for a full frame. SLOT_CYCLES=1, NOP_SLOTS=0 -> active cycles 0,1,2,3,4 continuously.

Source files
------------

// File: rtl/wts_channel_slot_scheduler.sv
// Channel-slot sequencer for the 5-channel ADSR envelope datapath. Generates the
// per-slot update strobe and issues pending key events aligned with each channel's strobe.
module wts_channel_slot_scheduler #(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned NOP_SLOTS   = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       enable,
  input  logic [4:0] key_on_req,
  input  logic [4:0] key_release_req,
  input  logic [4:0] key_off_req,
  output logic [2:0] active,
  output logic [2:0] slot,
  output logic       frame_start,
  output logic       ch_key_on,
  output logic       ch_key_release,
  output logic       ch_key_off,
  output logic [4:0] pending
);

  typedef enum logic [1:0] {EvNone, EvOn, EvRelease, EvOff} ev_e;

  localparam logic [3:0] CycLast  = 4'(SLOT_CYCLES - 1);
  localparam logic [2:0] SlotLast = 3'(4 + NOP_SLOTS);
  localparam logic [2:0] ActNop   = 3'd5;

  logic [3:0] cyc_q, cyc_d;
  logic [2:0] slot_q, slot_d;
  ev_e        ev_q [5];
  ev_e        ev_d [5];
  ev_e        issue_ev;
  logic       issue;

  // A channel slot is serviced only on its first cycle, so each channel updates once per frame.
  assign issue = enable && (cyc_q == 4'd0) && (slot_q <= 3'd4);

  always_comb begin
    cyc_d  = cyc_q;
    slot_d = slot_q;
    if (enable) begin
      if (cyc_q == CycLast) begin
        cyc_d  = 4'd0;
        slot_d = (slot_q == SlotLast) ? 3'd0 : slot_q + 3'd1;
      end else begin
        cyc_d = cyc_q + 4'd1;
      end
    end
  end

  always_comb begin
    issue_ev = EvNone;
    pending  = '0;
    for (int n = 0; n < 5; n++) begin
      if (issue && slot_q == 3'(n)) begin
        issue_ev = ev_q[n];
      end
      pending[n] = (ev_q[n] != EvNone);
      // A new request wins over the clear, so a request colliding with its issue waits a frame.
      if (key_off_req[n]) begin
        ev_d[n] = EvOff;
      end else if (key_release_req[n]) begin
        ev_d[n] = EvRelease;
      end else if (key_on_req[n]) begin
        ev_d[n] = EvOn;
      end else if (issue && slot_q == 3'(n)) begin
        ev_d[n] = EvNone;
      end else begin
        ev_d[n] = ev_q[n];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cyc_q          <= 4'd0;
      slot_q         <= 3'd0;
      active         <= ActNop;
      frame_start    <= 1'b0;
      ch_key_on      <= 1'b0;
      ch_key_release <= 1'b0;
      ch_key_off     <= 1'b0;
      for (int n = 0; n < 5; n++) begin
        ev_q[n] <= EvNone;
      end
    end else begin
      cyc_q          <= cyc_d;
      slot_q         <= slot_d;
      active         <= issue ? slot_q : ActNop;
      frame_start    <= issue && (slot_q == 3'd0);
      ch_key_on      <= (issue_ev == EvOn);
      ch_key_release <= (issue_ev == EvRelease);
      ch_key_off     <= (issue_ev == EvOff);
      for (int n = 0; n < 5; n++) begin
        ev_q[n] <= ev_d[n];
      end
    end
  end

  assign slot = slot_q;

endmodule
